// File: rtl/ubtb_update_ctrl_pkg.sv
// Shared uBTB definitions: update-entry payload and branch-type encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ubtb_update_ctrl_pkg;

    typedef enum logic [1:0] {
        BRANCH_TYPE_DIRECT   = 2'd0,
        BRANCH_TYPE_INDIRECT = 2'd1,
        BRANCH_TYPE_RETURN   = 2'd2,
        BRANCH_TYPE_CALL     = 2'd3
    } branch_type_e;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  target;
        logic [1:0]   cut_pos;
        branch_type_e branch_type;
    } upd_entry_t;

endpackage

// File: rtl/ubtb_upd_fifo.sv
// Update queue storage: circular buffer with occupancy count and PC-match coalescing.
// Latency: push visible at head one cycle later; head is a register mux, no input paths.
// Backpressure: caller must not push when full without a same-cycle pop, nor pop when empty.
// Ports: clk/rst_n (sync active-low), i_flush empties the queue, i_push/i_push_dat write the tail,
//        i_pop retires the head, i_co_vld requests an in-place coalesce of i_push_dat,
//        o_co_hit flags a live non-popping entry with the same PC, o_head/o_empty/o_full status.
module ubtb_upd_fifo
    import ubtb_update_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_flush,
    input  logic       i_push,
    input  upd_entry_t i_push_dat,
    input  logic       i_pop,
    input  logic       i_co_vld,
    output logic       o_co_hit,
    output upd_entry_t o_head,
    output logic       o_empty,
    output logic       o_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    upd_entry_t       r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_live;
    logic             w_co_hit;
    logic [PW-1:0]    w_co_idx;

    // An entry is live when its distance from the read pointer is below the occupancy.
    // The head is excluded from matching while it is being popped, so a same-PC
    // candidate then lands as a fresh tail entry instead of being lost with the pop.
    always_comb begin
        w_live   = '0;
        w_co_hit = 1'b0;
        w_co_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_live[i] = ({1'b0, PW'(i) - r_rd_ptr} < r_count);
            if (w_live[i] && !(i_pop && (PW'(i) == r_rd_ptr)) &&
                (r_mem[i].pc == i_push_dat.pc)) begin
                w_co_hit = 1'b1;
                w_co_idx = PW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_co_vld && w_co_hit) begin
                r_mem[w_co_idx].target      <= i_push_dat.target;
                r_mem[w_co_idx].cut_pos     <= i_push_dat.cut_pos;
                r_mem[w_co_idx].branch_type <= i_push_dat.branch_type;
            end
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_co_hit = w_co_hit;
    assign o_head   = r_mem[r_rd_ptr];
    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));

endmodule

// File: rtl/ubtb_update_ctrl.sv
// uBTB training-update controller: filters mispredicted taken resolves into a coalescing queue.
// Latency: one cycle from accepted resolve to the earliest update_valid.
// Backpressure: update_block holds the head; candidates arriving with a full, non-popping queue are dropped and counted.
// Ports: clk/rst_n (sync active-low); resolve_* and pred_* describe a resolved branch and its fetch-time prediction;
//        flush discards queued updates; update_block stalls issue; update_* is the uBTB write port;
//        queue_full and drop_cnt report queue pressure.
module ubtb_update_ctrl
    import ubtb_update_ctrl_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  resolve_valid,
    input  logic [31:0]           resolve_pc,
    input  logic                  resolve_taken,
    input  logic [31:0]           resolve_target,
    input  logic [1:0]            resolve_cut_pos,
    input  logic [1:0]            resolve_branch_type,
    input  logic                  pred_hit,
    input  logic [31:0]           pred_target,
    input  logic                  flush,
    input  logic                  update_block,
    output logic                  update_valid,
    output logic [31:0]           update_pc,
    output logic [31:0]           target_pc,
    output logic [1:0]            update_cut_pos,
    output logic [1:0]            update_branch_type,
    output logic                  queue_full,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    upd_entry_t            w_cand_dat;
    upd_entry_t            w_head;
    logic                  w_cand;
    logic                  w_co_hit;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    // Only taken branches the uBTB missed or mispredicted train it; a flush
    // cancels the candidate outright, so it neither enqueues nor counts as a drop.
    assign w_cand = resolve_valid && resolve_taken &&
                    (!pred_hit || (pred_target != resolve_target)) && !flush;

    assign w_cand_dat = '{pc:          resolve_pc,
                          target:      resolve_target,
                          cut_pos:     resolve_cut_pos,
                          branch_type: branch_type_e'(resolve_branch_type)};

    assign w_pop  = !w_empty && !update_block;
    // A pop frees a slot in the same edge, so a full queue still accepts then.
    assign w_push = w_cand && !w_co_hit && (!w_full || w_pop);
    assign w_drop = w_cand && !w_co_hit && w_full && !w_pop;

    ubtb_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (flush),
        .i_push     (w_push),
        .i_push_dat (w_cand_dat),
        .i_pop      (w_pop),
        .i_co_vld   (w_cand),
        .o_co_hit   (w_co_hit),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign update_valid       = w_pop;
    assign update_pc          = w_head.pc;
    assign target_pc          = w_head.target;
    assign update_cut_pos     = w_head.cut_pos;
    assign update_branch_type = w_head.branch_type;
    assign queue_full         = w_full;
    assign drop_cnt           = r_drop_cnt;

endmodule

// File: doc/ubtb_update_ctrl.md
UBTB_UPDATE_CTRL -- requirements
Module: ubtb_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4: update queue entries, power of two, minimum 2.
REQ-002 SHALL have parameter DROP_CNT_W, default 8: width of the dropped-update counter.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port resolve_valid  input  1: one resolved branch from the backend this cycle.
REQ-006 SHALL have port resolve_pc  input  32: PC of the resolved branch.
REQ-007 SHALL have port resolve_taken  input  1: branch actually taken.
REQ-008 SHALL have port resolve_target  input  32: actual target.
REQ-009 SHALL have port resolve_cut_pos  input  2: fetch-group cut position of the branch.
REQ-010 SHALL have port resolve_branch_type  input  2: direct/indirect/return/call encoding.
REQ-011 SHALL have port pred_hit  input  1: the uBTB hit when this branch was fetched.
REQ-012 SHALL have port pred_target  input  32: the uBTB next_fetch_pc given at fetch.
REQ-013 SHALL have port flush  input  1: discard all queued updates.
REQ-014 SHALL have port update_block  input  1: hold the queue; no update issued this cycle.
REQ-015 SHALL have port update_valid  output  1: write strobe to the uBTB update interface.
REQ-016 SHALL have ports update_pc / target_pc (output 32 each), update_cut_pos / update_branch_type (output 2 each): write payload.
REQ-017 SHALL have port queue_full  output  1: all DEPTH entries occupied.
REQ-018 SHALL have port drop_cnt  output  DROP_CNT_W: resolves lost because the queue was full.

Function
REQ-019 A resolve SHALL be a training candidate only if resolve_taken=1 and (pred_hit=0 or pred_target!=resolve_target); all other resolves are ignored and change no state.
REQ-020 A candidate SHALL be enqueued at the rising edge of its cycle; the earliest matching update_valid is the next cycle (latency 1).
REQ-021 update_valid SHALL equal queue non-empty and update_block=0; payload SHALL be the head entry, driven from registers only.
REQ-022 The head entry SHALL be popped at every edge where update_valid=1; at most one update per cycle; FIFO order preserved.
REQ-023 Coalescing: if a candidate's PC equals a queued non-popping entry's PC, that entry's target/cut_pos/branch_type SHALL be overwritten in place, with no new slot and no reorder.
REQ-024 If the matching entry is the head being popped this cycle, the candidate SHALL be enqueued as a new tail entry instead.
REQ-025 Candidate with queue full, no coalesce and no pop this cycle: SHALL be dropped and drop_cnt incremented, saturating at all-ones.
REQ-026 Candidate with queue full and a pop in the same cycle: SHALL be accepted; occupancy stays DEPTH.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter is clog2(DEPTH)+1 bits.
REQ-028 flush=1 SHALL empty the queue at that edge and suppress any same-cycle enqueue or coalesce; update_valid in a flush cycle still follows REQ-021.
REQ-029 drop_cnt SHALL be unaffected by flush.
REQ-030 update_block=1 SHALL freeze the head; enqueue, coalesce and drop behave normally.

Reset
REQ-031 rst_n=0 at an edge SHALL clear the queue and drop_cnt; it overrides all other inputs, including mid-operation.
REQ-032 During and after reset: update_valid=0, queue_full=0, drop_cnt=0, payload outputs 0, update_branch_type=BRANCH_TYPE_DIRECT.

Structure
REQ-033 The update-entry struct {pc, target, cut_pos, branch_type} and branch_type encodings SHALL reside in the shared defs, reused by the uBTB.
REQ-034 A single sub-module, ubtb_upd_fifo (storage, pointers, occupancy, PC-match coalesce port), SHALL be used; candidate filter and drop counter stay in the top.

Verification
REQ-035 Miss: resolve pc=0x1000 taken target=0x2000 pred_hit=0 -> next cycle update_valid=1, update_pc=0x1000, target_pc=0x2000; one cycle only.
REQ-036 Correct prediction: pc=0x1000 taken pred_hit=1 pred_target=0x2000=resolve_target -> update_valid stays 0.
REQ-037 Coalesce: update_block=1; candidates pc=0x1000 tgt 0x2000, then pc=0x1000 tgt 0x3000 -> release block: exactly one update, target_pc=0x3000.
REQ-038 Full: update_block=1; 5 distinct candidates at DEPTH=4 -> queue_full=1, drop_cnt=1; release: 4 updates, first four in order.
REQ-039 Full with pop: queue full, update_block=0, new candidate same cycle -> accepted, drop_cnt unchanged, queue_full stays 1.
REQ-040 Flush and reset: 3 entries queued, flush with a candidate same cycle -> queue empty next cycle, no update; repeat with rst_n=0 -> all outputs at reset values.
